muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_if.sv | 19 +
 rtl/muldiv_sequencer.sv | 101 ++++++++++
 tb/tb_muldiv_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: start/result valid-ready handshake bundle for muldiv_sequencer.
// master = issuer (drives start_valid/op/a/b, res_ready); slave = engine
// (drives start_ready, res_valid, res_hi, res_lo, err).
interface muldiv_sequencer_if #(parameter int WIDTH = 16);
    logic             start_valid;
    logic             start_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             err;
    modport master (output start_valid, op, a, b, res_ready,
                    input  start_ready, res_valid, res_hi, res_lo, err);
    modport slave  (input  start_valid, op, a, b, res_ready,
                    output start_ready, res_valid, res_hi, res_lo, err);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned WIDTHxWIDTH multiply / restoring divide, one step per cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport): start_valid/start_ready/op/a/b
// request, res_valid/res_ready/res_hi/res_lo/err result (op 0 = mul, 1 = div).
// Macro MULDIV_DIV_EN compiles in the divider; without it op=1 returns zeros with err=1.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [CW-1:0]    cnt;
    logic             err_q, fast;
    logic [WIDTH-1:0] fast_hi, fast_lo, load_lo, step_hi, step_lo;
    logic [WIDTH:0]   mul_sum;
`ifdef MULDIV_DIV_EN
    logic             op_q;
    logic [WIDTH:0]   div_sh, div_diff;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = (state == IDLE) ? (bus.start_valid ? RUN : IDLE) :
                  (state == RUN)  ? ((cnt == '0) ? DONE : RUN) :
                                    (bus.res_ready ? IDLE : DONE);
    end

    // Fast paths pass through RUN for exactly one edge (count loaded as 0) so
    // their result appears one edge after accept; err_q freezes the datapath.
    always_comb begin
`ifdef MULDIV_DIV_EN
        fast    = bus.op && (bus.b == '0);
        fast_hi = bus.a;
        fast_lo = '1;
        load_lo = bus.op ? bus.a : bus.b;
`else
        fast    = bus.op;
        fast_hi = '0;
        fast_lo = '0;
        load_lo = bus.b;
`endif
    end

    // Multiply: hi accumulates, lo holds the multiplier shifting out LSB-first.
    // Divide: {hi, lo} = {remainder, dividend/quotient} shifting left.
    always_comb begin
        mul_sum = {1'b0, hi} + {1'b0, lo[0] ? opnd : '0};
`ifdef MULDIV_DIV_EN
        div_sh   = {hi, lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        step_hi  = !op_q ? mul_sum[WIDTH:1] :
                   div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        step_lo  = !op_q ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~div_diff[WIDTH]};
`else
        step_hi  = mul_sum[WIDTH:1];
        step_lo  = {mul_sum[0], lo[WIDTH-1:1]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_q  <= 1'b0;
`endif
        end else if (state == IDLE && bus.start_valid) begin
            opnd  <= bus.op ? bus.b : bus.a;
            cnt   <= fast ? '0 : CW'(WIDTH - 1);
            err_q <= fast;
            hi    <= fast ? fast_hi : '0;
            lo    <= fast ? fast_lo : load_lo;
`ifdef MULDIV_DIV_EN
            op_q  <= bus.op;
`endif
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (!err_q) begin
                hi <= step_hi;
                lo <= step_lo;
            end
        end
    end

    always_comb begin
        bus.start_ready = (state == IDLE);
        bus.res_valid   = (state == DONE);
        bus.res_hi      = hi;
        bus.res_lo      = lo;
        bus.err         = err_q;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard-driven self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    muldiv_sequencer_if #(.WIDTH(16)) bus ();
    muldiv_sequencer #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic res_t model(input bit op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        if (!op) begin
            p = 32'(a) * 32'(b);
            return {p[31:16], p[15:0], 1'b0};
        end
`ifdef MULDIV_DIV_EN
        if (b == 16'h0) return {a, 16'hFFFF, 1'b1};
        return {a % b, a / b, 1'b0};
`else
        return {16'h0, 16'h0, 1'b1};
`endif
    endfunction

    function automatic int exp_lat(input bit op, input logic [15:0] b);
`ifdef MULDIV_DIV_EN
        return (op && b == 16'h0) ? 1 : 16;
`else
        return op ? 1 : 16;
`endif
    endfunction

    // Entered at a negedge just after the accept edge; counts edges until res_valid.
    task automatic wait_result(input bit consume, output res_t got, output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = {bus.res_hi, bus.res_lo, bus.err};
        if (consume && bus.res_valid) begin
            bus.res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic do_op(input bit op, input logic [15:0] a, input logic [15:0] b,
                         input bit consume, output res_t got, output int lat);
        int n = 0;
        while (!bus.start_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        bus.start_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        wait_result(consume, got, lat);
    endtask

    task automatic run_and_check(input string name, input bit op, input logic [15:0] a, input logic [15:0] b);
        res_t got, exp;
        int lat;
        sb.push_back(model(op, a, b));
        do_op(op, a, b, 1'b1, got, lat);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h err=%b, expected hi=%h lo=%h err=%b",
                     name, got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err);
        end
        checks++;
        if (lat !== exp_lat(op, b)) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat(op, b));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.start_ready, bus.res_valid, bus.res_hi, bus.res_lo, bus.err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset state: got rdy=%b vld=%b hi=%h lo=%h err=%b, expected rdy=1 vld=0 hi=0 lo=0 err=0",
                     bus.start_ready, bus.res_valid, bus.res_hi, bus.res_lo, bus.err);
        end
    endtask

    task automatic test_multiply;
        res_t k;
        run_and_check("mul_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF);
        k = {bus.res_hi, bus.res_lo, bus.err};
        checks++;
        if (k !== {16'hFFFE, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL mul_ffff_const: got hi=%h lo=%h err=%b, expected hi=fffe lo=0001 err=0", k.hi, k.lo, k.err);
        end
        run_and_check("mul_zero", 1'b0, 16'h0000, 16'h1234);
        run_and_check("mul_300_200", 1'b0, 16'd300, 16'd200);
        run_and_check("mul_one", 1'b0, 16'h0001, 16'hFFFF);
        for (int i = 0; i < 4; i++)
            run_and_check("mul_rand", 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic test_divide;
        run_and_check("div_1000_7", 1'b1, 16'd1000, 16'd7);
        run_and_check("div_5_9", 1'b1, 16'd5, 16'd9);
        run_and_check("div_ffff_1", 1'b1, 16'hFFFF, 16'h0001);
        run_and_check("div_100_10", 1'b1, 16'd100, 16'd10);
        for (int i = 0; i < 4; i++)
            run_and_check("div_rand", 1'b1, 16'($urandom), 16'($urandom_range(1, 300)));
    endtask

    task automatic test_div_zero;
        run_and_check("div_by_zero", 1'b1, 16'h1234, 16'h0000);
    endtask

    task automatic test_backpressure;
        res_t got, exp;
        int lat;
        sb.push_back(model(1'b0, 16'd7, 16'd9));
        do_op(1'b0, 16'd7, 16'd9, 1'b0, got, lat);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || !bus.res_valid) begin
            errors++;
            $display("FAIL bp_first: got vld=%b hi=%h lo=%h err=%b, expected vld=1 hi=%h lo=%h err=%b",
                     bus.res_valid, got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err);
        end
        bus.start_valid = 1'b1;
        bus.op = 1'b0;
        bus.a = 16'd11;
        bus.b = 16'd13;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.res_valid, bus.start_ready, bus.res_hi, bus.res_lo, bus.err} !== {1'b1, 1'b0, exp}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b hi=%h lo=%h err=%b, expected vld=1 rdy=0 hi=%h lo=%h err=%b",
                         i, bus.res_valid, bus.start_ready, bus.res_hi, bus.res_lo, bus.err, exp.hi, exp.lo, exp.err);
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if ({bus.start_ready, bus.res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b, expected rdy=1 vld=0", bus.start_ready, bus.res_valid);
        end
        sb.push_back(model(1'b0, 16'd11, 16'd13));
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got rdy=%b, expected rdy=0", bus.start_ready);
        end
        wait_result(1'b1, got, lat);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || lat !== 16) begin
            errors++;
            $display("FAIL bp_second: got hi=%h lo=%h err=%b lat=%0d, expected hi=%h lo=%h err=%b lat=16",
                     got.hi, got.lo, got.err, lat, exp.hi, exp.lo, exp.err);
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op = 1'b0;
        bus.a = 16'd300;
        bus.b = 16'd200;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.start_ready, bus.res_valid, bus.res_hi, bus.res_lo, bus.err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b vld=%b hi=%h lo=%h err=%b, expected rdy=1 vld=0 hi=0 lo=0 err=0",
                     bus.start_ready, bus.res_valid, bus.res_hi, bus.res_lo, bus.err);
        end
        run_and_check("post_reset_3x4", 1'b0, 16'd3, 16'd4);
    endtask

    task automatic test_back_to_back;
        logic [15:0] av[2] = '{16'h1234, 16'd1000};
        logic [15:0] bv[2] = '{16'h5678, 16'd77};
        int   acc_cyc[2] = '{0, 0};
        int   nacc = 0;
        int   nres = 0;
        res_t got, exp;
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b1;
        bus.op = 1'b0;
        bus.a = av[0];
        bus.b = bv[0];
        for (int cyc = 0; cyc < 80 && nres < 2; cyc++) begin
            if (bus.res_valid) begin
                got = {bus.res_hi, bus.res_lo, bus.err};
                exp = sb.pop_front();
                nres++;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got hi=%h lo=%h err=%b, expected hi=%h lo=%h err=%b",
                             nres, got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err);
                end
            end
            if (bus.start_valid && bus.start_ready && nacc < 2) begin
                sb.push_back(model(1'b0, av[nacc], bv[nacc]));
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            @(negedge clk);
            if (nacc == 2) bus.start_valid = 1'b0;
            else begin
                bus.a = av[nacc];
                bus.b = bv[nacc];
            end
        end
        bus.res_ready = 1'b0;
        bus.start_valid = 1'b0;
        checks++;
        if (nres !== 2 || acc_cyc[1] - acc_cyc[0] !== 18) begin
            errors++;
            $display("FAIL b2b_spacing: got results=%0d spacing=%0d, expected results=2 spacing=18",
                     nres, acc_cyc[1] - acc_cyc[0]);
        end
        sb.delete();
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.op = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
